instr_dispatch: RTL and testbench
=================================

// Module: instr_dispatch
// PURPOSE
//  Fetch/decode/dispatch controller upstream of the per-opcode execution FSMs.
//  Each instruction is {op[3:0], Ri[5:0], Rj[5:0]}; e.g. 0111 = move.
//  Fetches by PC, decodes the opcode and pulses that unit's start line.
//  Holds Ri/Rj stable until the unit's done, then advances the PC.
// PARAMETERS
//  PCW        8        program counter / instruction address width
//  RESET_PC   0        PC value after reset
//  UNIT_MASK  16'h00FF bit k=1: opcode k has an execution unit attached
//  TIMEOUT    64       watchdog limit in cycles (only with DISPATCH_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  run          in   1    level; begin/continue execution when 1
//  instr_req    out  1    fetch request, held until instr_valid
//  instr_addr   out  PCW  fetch address (= pc)
//  instr_valid  in   1    instr_data valid this cycle
//  instr_data   in   16   {op, Ri, Rj}
//  unit_start   out  16   one-hot start pulse, bit = opcode
//  unit_done    in   16   per-unit done, bit = opcode
//  Ri           out  6    destination operand to units
//  Rj           out  6    source operand to units
//  pc           out  PCW  current program counter
//  busy         out  1    1 in any state except IDLE and HALT
//  halted       out  1    1 in HALT
//  err          out  1    sticky; unimplemented opcode or timeout
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, pc=RESET_PC; all other outputs 0.
//  States: IDLE, FETCH, DECODE, DISPATCH, WAIT, ADVANCE, HALT.
//  IDLE: go to FETCH when run=1.
//  FETCH: instr_req=1, instr_addr=pc.
//   - If instr_valid=1: capture instr_data into IR, drop instr_req next cycle, go to DECODE.
//   - instr_valid in the request cycle is accepted (zero-wait memory).
//  DECODE (1 cycle): drive Ri=IR[11:6], Rj=IR[5:0].
//   - op=4'hF: HALT.
//   - op=4'h0: NOP, go to ADVANCE.
//   - UNIT_MASK[op]=0: set err, go to HALT.
//   - Otherwise: DISPATCH.
//  DISPATCH (1 cycle): unit_start[op]=1, all other bits 0; go to WAIT.
//  WAIT: unit_start=0; Ri/Rj held. Leave when unit_done[op]=1, go to ADVANCE.
//   - unit_done bits of other opcodes are ignored.
//   - unit_done[op] already 1 in the DISPATCH cycle is ignored; only WAIT samples it.
//  ADVANCE (1 cycle): pc<=pc+1, modulo 2^PCW (wraps to 0).
//   - run=1: FETCH. run=0: IDLE.
//  Ri/Rj change only in DECODE, so they are stable from start pulse to done.
//  HALT: halted=1. Exit only by reset; run is ignored.
//  Minimum per instruction: FETCH 1 + DECODE 1 + DISPATCH 1 + WAIT n + ADVANCE 1.
//  Dropping run mid-instruction does not abort; the instruction completes, then IDLE.
//  Reset mid-WAIT: immediate return to IDLE. unit_start stays 0, so no unit is re-started.
// CONFIGURATION
//  DISPATCH_TIMEOUT_EN defined:
//   - 8-bit wait counter cleared on WAIT entry, increments each WAIT cycle.
//   - Reaching TIMEOUT without unit_done[op]: err=1, go to HALT.
//  DISPATCH_TIMEOUT_EN undefined:
//   - No counter; WAIT is unbounded; err is set only by an unimplemented opcode.
// TESTING
//  T1 move: run=1, mem[0]=16'h7042 (op7, Ri=1, Rj=2), unit7 done 2 cycles after start.
//   -> unit_start=16'h0080 for 1 cycle; Ri=1, Rj=2 held until done; pc 0->1.
//  T2 NOP then HALT: mem[0]=16'h0000, mem[1]=16'hF000.
//   -> no unit_start pulse; pc=1; halted=1; run toggling has no effect.
//  T3 unimplemented opcode: UNIT_MASK=16'h00FF, mem[0]=16'h9000.
//   -> err=1, halted=1, unit_start never asserted.
//  T4 stray done: during WAIT on op7, pulse unit_done[3].
//   -> stays in WAIT; advances only on unit_done[7].
//  T5 wrap and run drop: PCW=8, pc=8'hFF, op7 completes with run=0 during WAIT.
//   -> pc=8'h00, state IDLE, busy=0.
//  T6 reset and timeout: reset=0 mid-WAIT -> all outputs 0, pc=RESET_PC.
//   With DISPATCH_TIMEOUT_EN and TIMEOUT=64, unit never done -> err=1, halted=1.

Source files
------------

// File: rtl/instr_dispatch.sv
// Fetch/decode/dispatch controller that sends each {op, Ri, Rj} instruction to its execution unit.
// Optional watchdog on unit completion: define DISPATCH_TIMEOUT_EN (limit given by TIMEOUT).
module instr_dispatch #(
    parameter int unsigned     PCW       = 8,
    parameter logic [PCW-1:0]  RESET_PC  = '0,
    parameter logic [15:0]     UNIT_MASK = 16'h00FF
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter int unsigned     TIMEOUT   = 64
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    output logic           instr_req,
    output logic [PCW-1:0] instr_addr,
    input  logic           instr_valid,
    input  logic [15:0]    instr_data,
    output logic [15:0]    unit_start,
    input  logic [15:0]    unit_done,
    output logic [5:0]     Ri,
    output logic [5:0]     Rj,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           halted,
    output logic           err
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, DISPATCH, WAIT, ADVANCE, HALT
    } state_t;

    state_t     state, next_state;
    logic [3:0] ir_op;
    logic       set_err;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 wait_cnt <= '0;
        else if (state == DISPATCH) wait_cnt <= '0;
        else if (state == WAIT)     wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unit_start = '0;
        set_err    = 1'b0;
        unique case (state)
            IDLE:     if (run) next_state = FETCH;
            FETCH:    if (instr_valid) next_state = DECODE;
            DECODE: begin
                if (ir_op == 4'hF)          next_state = HALT;
                else if (ir_op == 4'h0)     next_state = ADVANCE;
                else if (!UNIT_MASK[ir_op]) begin
                    set_err    = 1'b1;
                    next_state = HALT;
                end
                else                        next_state = DISPATCH;
            end
            DISPATCH: begin
                unit_start[ir_op] = 1'b1;
                next_state        = WAIT;
            end
            WAIT: begin
                if (unit_done[ir_op]) next_state = ADVANCE;
`ifdef DISPATCH_TIMEOUT_EN
                else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    set_err    = 1'b1;
                    next_state = HALT;
                end
`endif
            end
            ADVANCE:  next_state = run ? FETCH : IDLE;
            HALT:     next_state = HALT;
            default:  next_state = IDLE;
        endcase
    end

    // Operands load as the fetch completes, so they are already valid in DECODE
    // and cannot change again until the next instruction is fetched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            ir_op <= '0;
            Ri    <= '0;
            Rj    <= '0;
            err   <= 1'b0;
        end else begin
            if (state == FETCH && instr_valid) begin
                ir_op <= instr_data[15:12];
                Ri    <= instr_data[11:6];
                Rj    <= instr_data[5:0];
            end
            if (state == ADVANCE) pc <= pc + PCW'(1);
            if (set_err)          err <= 1'b1;
        end
    end

    assign instr_req  = (state == FETCH);
    assign instr_addr = pc;
    assign busy       = (state != IDLE) && (state != HALT);
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: instruction-level reference model with random
// memory wait states, unit latencies, stray done pulses and run toggling.
module tb_instr_dispatch;

    localparam int unsigned    PCW       = 8;
    localparam logic [PCW-1:0] RESET_PC  = '0;
    localparam logic [15:0]    UNIT_MASK = 16'h00FF;
    localparam int             TIMEOUT   = 64;

    logic           clk;
    logic           reset;
    logic           run;
    logic           instr_req;
    logic [PCW-1:0] instr_addr;
    logic           instr_valid;
    logic [15:0]    instr_data;
    logic [15:0]    unit_start;
    logic [15:0]    unit_done;
    logic [5:0]     Ri;
    logic [5:0]     Rj;
    logic [PCW-1:0] pc;
    logic           busy;
    logic           halted;
    logic           err;

    instr_dispatch #(
        .PCW       (PCW),
        .RESET_PC  (RESET_PC),
        .UNIT_MASK (UNIT_MASK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .Ri          (Ri),
        .Rj          (Rj),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [15:0] mem [256];
    int unsigned p_valid  = 100;
    bit          unit_en  = 1'b1;
    bit          stray_en = 1'b0;

    // reference model: current-cycle expectations
    logic [PCW-1:0] m_pc;
    bit             m_halt, in_fetch;
    logic           e_req, e_busy, e_halt, e_err;
    logic [15:0]    e_start;
    logic [5:0]     e_ri, e_rj;
    logic           s_run, s_valid;
    logic [15:0]    s_data, s_done;
    int             m_left;

    // start-pulse monitor
    int          n_starts;
    logic [15:0] last_start;
    logic [5:0]  ri_at_start, rj_at_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (unit_start != 16'h0) begin
            n_starts++;
            last_start  = unit_start;
            ri_at_start = Ri;
            rj_at_start = Rj;
        end
        if (chk_en) begin
            n_vec++;
            if (instr_req !== e_req || instr_addr !== m_pc || unit_start !== e_start ||
                Ri !== e_ri || Rj !== e_rj || pc !== m_pc || busy !== e_busy ||
                halted !== e_halt || err !== e_err) begin
                n_bad++;
                $display("FAIL cycle_compare t=%0t got/exp: req %b/%b addr %h/%h start %h/%h Ri %0d/%0d Rj %0d/%0d pc %h/%h busy %b/%b halted %b/%b err %b/%b",
                         $time, instr_req, e_req, instr_addr, m_pc, unit_start, e_start,
                         Ri, e_ri, Rj, e_rj, pc, m_pc, busy, e_busy, halted, e_halt, err, e_err);
            end
        end
    end

    // zero-or-more-wait instruction memory; data is garbage whenever valid is low
    initial forever begin
        @(posedge clk); #2;
        if ($urandom_range(0, 99) < p_valid) begin
            instr_valid = 1'b1;
            instr_data  = mem[instr_addr];
        end else begin
            instr_valid = 1'b0;
            instr_data  = 16'($urandom);
        end
    end

    // execution units: done 1..4 cycles after the start pulse, optional early and stray pulses
    bit          pending;
    logic [3:0]  p_op;
    int          p_cnt;
    logic [15:0] d;
    initial begin
        pending   = 1'b0;
        unit_done = '0;
        forever begin
            @(posedge clk); #2;
            d = '0;
            if (!reset) begin
                pending = 1'b0;
            end else begin
                if (pending && unit_en) begin
                    if (p_cnt == 1) begin
                        d[p_op] = 1'b1;
                        pending = 1'b0;
                    end else begin
                        p_cnt--;
                    end
                end
                if (unit_start != 16'h0) begin
                    for (int k = 0; k < 16; k++) if (unit_start[k]) p_op = 4'(k);
                    pending = 1'b1;
                    p_cnt   = int'($urandom_range(1, 4));
                    if (stray_en && $urandom_range(0, 2) == 0) d[p_op] = 1'b1;
                end
                if (stray_en) d = d | (16'($urandom) & ~(pending ? (16'd1 << p_op) : 16'd0));
            end
            unit_done = d;
        end
    end

    function automatic void model_reset();
        m_pc     = RESET_PC;
        m_halt   = 1'b0;
        in_fetch = 1'b0;
        e_req    = 1'b0;
        e_busy   = 1'b0;
        e_halt   = 1'b0;
        e_err    = 1'b0;
        e_start  = '0;
        e_ri     = '0;
        e_rj     = '0;
    endfunction

    function automatic void enter_halt(input bit with_err);
        m_halt  = 1'b1;
        e_halt  = 1'b1;
        e_busy  = 1'b0;
        e_req   = 1'b0;
        e_start = '0;
        if (with_err) e_err = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        s_run   = run;
        s_valid = instr_valid;
        s_data  = instr_data;
        s_done  = unit_done;
        m_left--;
    endtask

    // Walks instruction by instruction, updating what the outputs must be after each edge.
    task automatic model(input int budget);
        logic [15:0] ir;
        logic [3:0]  op;
`ifdef DISPATCH_TIMEOUT_EN
        int waited;
`endif
        m_left = budget;
        while (m_left > 0) begin
            if (m_halt || !in_fetch) begin
                tick();
                if (!m_halt && s_run) begin
                    in_fetch = 1'b1;
                    e_req    = 1'b1;
                    e_busy   = 1'b1;
                end
                continue;
            end
            tick();
            if (!s_valid) continue;
            in_fetch = 1'b0;
            ir       = s_data;
            op       = ir[15:12];
            e_req    = 1'b0;
            e_ri     = ir[11:6];
            e_rj     = ir[5:0];
            if (m_left <= 0) return;
            tick();
            if (op == 4'hF) begin
                enter_halt(1'b0);
                continue;
            end
            if (op != 4'h0 && !UNIT_MASK[op]) begin
                enter_halt(1'b1);
                continue;
            end
            if (op != 4'h0) begin
                e_start = 16'd1 << op;
                if (m_left <= 0) return;
                tick();
                e_start = '0;
`ifdef DISPATCH_TIMEOUT_EN
                waited = 0;
`endif
                forever begin
                    if (m_left <= 0) return;
                    tick();
                    if (s_done[op]) break;
`ifdef DISPATCH_TIMEOUT_EN
                    waited++;
                    if (waited == TIMEOUT) break;
`endif
                end
                if (!s_done[op]) begin
                    enter_halt(1'b1);
                    continue;
                end
            end
            if (m_left <= 0) return;
            tick();
            m_pc = m_pc + 1'b1;
            if (s_run) begin
                in_fetch = 1'b1;
                e_req    = 1'b1;
            end else begin
                e_busy = 1'b0;
            end
        end
    endtask

    task automatic reset_dut();
        chk_en = 1'b0;
        run    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        n_starts = 0;
        chk_en   = 1'b1;
    endtask

    task automatic settle();
        chk_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_mem(input logic [15:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        n_starts    = 0;
        model_reset();

        // reset state
        reset_dut();
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'(RESET_PC));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_start", 32'(unit_start), 32'(0));
        check("rst_req", 32'(instr_req), 32'(0));

        // T1 move
        fill_mem(16'hF000);
        mem[0] = 16'h7042;
        p_valid = 100; unit_en = 1'b1; stray_en = 1'b0;
        reset_dut();
        run = 1'b1;
        model(30);
        settle();
        check("t1_start_value", 32'(last_start), 32'h0080);
        check("t1_start_count", 32'(n_starts), 32'(1));
        check("t1_ri_at_start", 32'(ri_at_start), 32'(1));
        check("t1_rj_at_start", 32'(rj_at_start), 32'(2));
        check("t1_pc", 32'(pc), 32'(1));
        check("t1_halted", 32'(halted), 32'(1));

        // T2 NOP then HALT with run toggling
        fill_mem(16'hF000);
        mem[0] = 16'h0000;
        reset_dut();
        fork
            model(40);
            begin
                run = 1'b1;
                repeat (15) @(posedge clk);
                repeat (20) begin
                    @(posedge clk); #2;
                    run = 1'($urandom_range(0, 1));
                end
            end
        join
        settle();
        check("t2_start_count", 32'(n_starts), 32'(0));
        check("t2_pc", 32'(pc), 32'(1));
        check("t2_halted", 32'(halted), 32'(1));
        check("t2_busy", 32'(busy), 32'(0));

        // T3 unimplemented opcode
        fill_mem(16'h9000);
        reset_dut();
        run = 1'b1;
        model(20);
        settle();
        check("t3_err", 32'(err), 32'(1));
        check("t3_halted", 32'(halted), 32'(1));
        check("t3_start_count", 32'(n_starts), 32'(0));
        check("t3_pc", 32'(pc), 32'(0));

        // T4 stray and early done pulses around a move
        fill_mem(16'hF000);
        mem[0] = 16'h7042;
        stray_en = 1'b1;
        reset_dut();
        run = 1'b1;
        model(30);
        settle();
        check("t4_start_count", 32'(n_starts), 32'(1));
        check("t4_pc", 32'(pc), 32'(1));
        stray_en = 1'b0;

        // T5 pc wrap with run dropped during WAIT
        fill_mem(16'h0000);
        mem[255] = 16'h7042;
        reset_dut();
        fork
            model(1000);
            begin
                run = 1'b1;
                for (int i = 0; i < 950 && unit_start == 16'h0; i++) begin
                    @(posedge clk); #2;
                end
                run = 1'b0;
            end
        join
        settle();
        check("t5_start_count", 32'(n_starts), 32'(1));
        check("t5_pc_wrap", 32'(pc), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_halted", 32'(halted), 32'(0));

        // T6 reset in the middle of WAIT
        fill_mem(16'h7042);
        unit_en = 1'b0;
        reset_dut();
        run = 1'b1;
        model(8);
        settle();
        check("t6_in_wait_busy", 32'(busy), 32'(1));
        check("t6_in_wait_start", 32'(unit_start), 32'(0));
        #1 reset = 1'b0;
        #1;
        check("t6_rst_pc", 32'(pc), 32'(RESET_PC));
        check("t6_rst_busy", 32'(busy), 32'(0));
        check("t6_rst_ri", 32'(Ri), 32'(0));
        check("t6_rst_rj", 32'(Rj), 32'(0));
        check("t6_rst_req", 32'(instr_req), 32'(0));
        repeat (3) @(negedge clk);
        check("t6_no_restart", 32'(n_starts), 32'(1));

        // T6 unit that never finishes
        reset_dut();
        run = 1'b1;
        model(TIMEOUT + 20);
        settle();
`ifdef DISPATCH_TIMEOUT_EN
        check("t6_timeout_err", 32'(err), 32'(1));
        check("t6_timeout_halted", 32'(halted), 32'(1));
`else
        check("t6_unbounded_busy", 32'(busy), 32'(1));
        check("t6_unbounded_err", 32'(err), 32'(0));
`endif
        unit_en = 1'b1;

        // randomized programs, wait states, run level and stray done pulses
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                int unsigned sel;
                logic [3:0]  op;
                sel = $urandom_range(0, 99);
                if (sel < 10)      op = 4'h0;
                else if (sel < 94) op = 4'($urandom_range(1, 7));
                else if (sel < 97) op = 4'($urandom_range(8, 14));
                else               op = 4'hF;
                mem[i] = {op, 12'($urandom)};
            end
            p_valid  = 60;
            stray_en = 1'b1;
            reset_dut();
            fork
                model(300);
                begin
                    repeat (300) begin
                        @(posedge clk); #2;
                        run = ($urandom_range(0, 9) < 8);
                    end
                end
            join
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
